// File: rtl/event_filter_pkg.sv
// event_filter_pkg: shared definitions for the streaming event filter.
//   - POL_* : cfg_pol_mode encodings
//   - event_t : packed {x, y, t, p} event at default 16/16/16/1 widths
//   - fifo_width() : FIFO data width for a given set of field widths
package event_filter_pkg;

    localparam logic [1:0] POL_NONE = 2'b00;
    localparam logic [1:0] POL_ON   = 2'b01;
    localparam logic [1:0] POL_OFF  = 2'b10;
    localparam logic [1:0] POL_BOTH = 2'b11;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        logic        p;
    } event_t;

    function automatic int fifo_width(input int xw, input int yw, input int tw);
        return xw + yw + tw + 1;
    endfunction

endpackage

// File: rtl/event_filter_stream_fifo.sv
// event_fifo: synchronous FIFO, async active-low reset.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   push, push_data     write strobe and data (ignored when full)
//   pop, pop_data       read strobe (ignored when empty), head data
//   full, empty, count  occupancy status, all registered-derived
module event_fifo #(
    parameter int DW    = 49,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            // DEPTH is a power of two, so pointers wrap naturally
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/event_filter_stream.sv
// event_filter_stream: streaming address-event filter (polarity, optional ROI,
// per-pixel refractory) feeding an output FIFO.
// Optional feature macro: EVENT_FILTER_ROI_EN adds cfg_roi_* ports and ROI check.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   in_valid/in_ready, in_x/y/t/p  input event stream
//   cfg_pol_mode                   00 none, 01 ON only, 10 OFF only, 11 both
//   cfg_refract                    refractory window in ticks (0 = off)
//   cfg_roi_{x,y}_{min,max}        inclusive ROI window (macro only)
//   out_valid/out_ready, out_x/y/t/p  FIFO head event stream
//   drop_cnt                       saturating count of filtered events
module event_filter_stream
    import event_filter_pkg::*;
#(
    parameter int XW    = 16,
    parameter int YW    = 16,
    parameter int TW    = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XW-1:0]    in_x,
    input  logic [YW-1:0]    in_y,
    input  logic [TW-1:0]    in_t,
    input  logic             in_p,
    input  logic [1:0]       cfg_pol_mode,
    input  logic [TW-1:0]    cfg_refract,
`ifdef EVENT_FILTER_ROI_EN
    input  logic [XW-1:0]    cfg_roi_x_min,
    input  logic [XW-1:0]    cfg_roi_x_max,
    input  logic [YW-1:0]    cfg_roi_y_min,
    input  logic [YW-1:0]    cfg_roi_y_max,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic [TW-1:0]    out_t,
    output logic             out_p,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int DW = fifo_width(XW, YW, TW);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XW-1:0]    last_x_q, last_x_d;
    logic [YW-1:0]    last_y_q, last_y_d;
    logic [TW-1:0]    last_t_q, last_t_d;
    logic             last_p_q, last_p_d;
    logic             last_vld_q, last_vld_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [DW-1:0]    fifo_wdata, fifo_rdata;
    logic             accept, push, pop;
    logic             pol_pass, roi_pass, refr_fail;
    logic [TW-1:0]    delta_t;

    // in_ready comes only from registered occupancy, never from out_ready
    assign in_ready = (fifo_count < CW'(DEPTH));
    assign accept   = in_valid && !fifo_full;
    assign pop      = !fifo_empty && out_ready;

    always_comb begin
        case (cfg_pol_mode)
            POL_ON:   pol_pass = in_p;
            POL_OFF:  pol_pass = !in_p;
            POL_BOTH: pol_pass = 1'b1;
            default:  pol_pass = 1'b0;
        endcase
    end

`ifdef EVENT_FILTER_ROI_EN
    // An inverted window (min > max) can never be satisfied, so it drops all
    assign roi_pass = (in_x >= cfg_roi_x_min) && (in_x <= cfg_roi_x_max) &&
                      (in_y >= cfg_roi_y_min) && (in_y <= cfg_roi_y_max);
`else
    assign roi_pass = 1'b1;
`endif

    // Modular TW-bit difference handles timestamp wrap without a special case
    assign delta_t   = in_t - last_t_q;
    assign refr_fail = last_vld_q && (in_x == last_x_q) && (in_y == last_y_q) &&
                       (in_p == last_p_q) && (delta_t < cfg_refract);

    assign push       = accept && pol_pass && roi_pass && !refr_fail;
    assign fifo_wdata = {in_x, in_y, in_t, in_p};

    always_comb begin
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        last_t_d   = last_t_q;
        last_p_d   = last_p_q;
        last_vld_d = last_vld_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            last_x_d   = in_x;
            last_y_d   = in_y;
            last_t_d   = in_t;
            last_p_d   = in_p;
            last_vld_d = 1'b1;
        end else if (accept && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_x_q   <= '0;
            last_y_q   <= '0;
            last_t_q   <= '0;
            last_p_q   <= 1'b0;
            last_vld_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
            last_t_q   <= last_t_d;
            last_p_q   <= last_p_d;
            last_vld_q <= last_vld_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    event_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_wdata),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    // Idle head reads as zero rather than exposing stale storage
    assign {out_x, out_y, out_t, out_p} = fifo_empty ? '0 : fifo_rdata;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_event_filter_stream.sv
// tb_event_filter_stream: directed, table-driven bench for event_filter_stream.
module tb_event_filter_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x, in_y, in_t;
    logic        in_p;
    logic [1:0]  cfg_pol_mode;
    logic [15:0] cfg_refract;
`ifdef EVENT_FILTER_ROI_EN
    logic [15:0] cfg_roi_x_min, cfg_roi_x_max, cfg_roi_y_min, cfg_roi_y_max;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x, out_y, out_t;
    logic        out_p;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    event_filter_stream #(
        .XW(16), .YW(16), .TW(16), .DEPTH(4), .CNT_W(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_t          (in_t),
        .in_p          (in_p),
        .cfg_pol_mode  (cfg_pol_mode),
        .cfg_refract   (cfg_refract),
`ifdef EVENT_FILTER_ROI_EN
        .cfg_roi_x_min (cfg_roi_x_min),
        .cfg_roi_x_max (cfg_roi_x_max),
        .cfg_roi_y_min (cfg_roi_y_min),
        .cfg_roi_y_max (cfg_roi_y_max),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_t         (out_t),
        .out_p         (out_p),
        .drop_cnt      (drop_cnt)
    );

    typedef struct {
        logic [15:0] x, y, t;
        logic        p;
        logic [1:0]  mode;
        logic [15:0] refr;
        bit          pass;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one event with out_ready=1, check result after the accepting edge,
    // then spend one more cycle so a passed event drains.
    task automatic apply(input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] t, input logic p, input bit exp_pass);
        int unsigned guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_before_send", in_ready, 1);
        in_x = x; in_y = y; in_t = t; in_p = p; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!exp_pass) exp_drop++;
        chk("out_valid", out_valid, exp_pass);
        if (exp_pass) begin
            chk("out_x", out_x, x);
            chk("out_y", out_y, y);
            chk("out_t", out_t, t);
            chk("out_p", out_p, p);
        end
        chk("drop_cnt", drop_cnt, exp_drop);
        @(posedge clk); #1;
    endtask

    task automatic push_one(input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] t, input logic p);
        in_x = x; in_y = y; in_t = t; in_p = p; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [15:0] bp_x [6];
    int          accepted;
    int          n_out;

    initial begin
        vecs[0]  = '{16'd5, 16'd7, 16'd100,   1'b1, 2'b01, 16'd0,   1'b1};
        vecs[1]  = '{16'd5, 16'd7, 16'd101,   1'b0, 2'b01, 16'd0,   1'b0};
        vecs[2]  = '{16'd5, 16'd7, 16'd102,   1'b1, 2'b01, 16'd0,   1'b1};
        vecs[3]  = '{16'd1, 16'd1, 16'd0,     1'b1, 2'b10, 16'd0,   1'b0};
        vecs[4]  = '{16'd1, 16'd1, 16'd0,     1'b0, 2'b10, 16'd0,   1'b1};
        vecs[5]  = '{16'd2, 16'd2, 16'd5,     1'b0, 2'b00, 16'd0,   1'b0};
        vecs[6]  = '{16'd5, 16'd7, 16'd65500, 1'b1, 2'b11, 16'd100, 1'b1};
        vecs[7]  = '{16'd5, 16'd7, 16'd20,    1'b1, 2'b11, 16'd100, 1'b0};
        vecs[8]  = '{16'd5, 16'd7, 16'd200,   1'b1, 2'b11, 16'd100, 1'b1};
        vecs[9]  = '{16'd5, 16'd7, 16'd299,   1'b1, 2'b11, 16'd100, 1'b0};
        vecs[10] = '{16'd5, 16'd7, 16'd300,   1'b1, 2'b11, 16'd100, 1'b1};
        vecs[11] = '{16'd5, 16'd7, 16'd310,   1'b0, 2'b11, 16'd100, 1'b1};
        vecs[12] = '{16'd6, 16'd7, 16'd311,   1'b0, 2'b11, 16'd100, 1'b1};
        vecs[13] = '{16'd6, 16'd8, 16'd312,   1'b0, 2'b11, 16'd100, 1'b1};
        vecs[14] = '{16'd6, 16'd8, 16'd312,   1'b0, 2'b11, 16'd0,   1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_t = '0; in_p = 1'b0;
        cfg_pol_mode = 2'b11; cfg_refract = '0; out_ready = 1'b1;
`ifdef EVENT_FILTER_ROI_EN
        cfg_roi_x_min = 16'h0000; cfg_roi_x_max = 16'hFFFF;
        cfg_roi_y_min = 16'h0000; cfg_roi_y_max = 16'hFFFF;
`endif
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_out_x", out_x, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: polarity, wrap-safe refractory, window boundary, distinct pixels
        for (int i = 0; i < 15; i++) begin
            cfg_pol_mode = vecs[i].mode;
            cfg_refract  = vecs[i].refr;
            apply(vecs[i].x, vecs[i].y, vecs[i].t, vecs[i].p, vecs[i].pass);
        end

`ifdef EVENT_FILTER_ROI_EN
        cfg_pol_mode = 2'b11; cfg_refract = '0;
        cfg_roi_x_min = 16'd10; cfg_roi_x_max = 16'd20;
        apply(16'd9,  16'd3, 16'd1, 1'b1, 1'b0);
        apply(16'd10, 16'd3, 16'd2, 1'b1, 1'b1);
        apply(16'd20, 16'd3, 16'd3, 1'b1, 1'b1);
        apply(16'd21, 16'd3, 16'd4, 1'b1, 1'b0);
        cfg_roi_x_min = 16'd30; cfg_roi_x_max = 16'd20;
        apply(16'd25, 16'd3, 16'd5, 1'b1, 1'b0);
        cfg_roi_x_min = 16'h0000; cfg_roi_x_max = 16'hFFFF;
`endif

        // Backpressure: 6 events offered with out_ready low, only 4 accepted
        cfg_pol_mode = 2'b11; cfg_refract = '0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) bp_x[i] = 16'(100 + i);
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            in_x = bp_x[accepted]; in_y = 16'd50; in_t = 16'(c); in_p = 1'b1;
            in_valid = 1'b1;
            if (in_ready) accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", accepted, 4);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_head_stable", out_x, bp_x[0]);
        n_out = 1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after_pop", in_ready, 1);
        for (int g = 0; g < 10 && n_out < 4; g++) begin
            if (out_valid) begin
                chk("bp_drain_order", out_x, bp_x[n_out]);
                n_out++;
            end
            @(posedge clk); #1;
        end
        chk("bp_drain_count", n_out, 4);
        chk("bp_empty_after", out_valid, 0);

        // Reset with 3 events buffered, then a repeat that would be refractory
        cfg_refract = 16'd100; out_ready = 1'b0;
        push_one(16'd9, 16'd9, 16'd1000, 1'b1);
        push_one(16'd9, 16'd9, 16'd1500, 1'b1);
        push_one(16'd9, 16'd9, 16'd2000, 1'b1);
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        exp_drop = 0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_x", out_x, 0);
        chk("mid_rst_out_t", out_t, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_drop_cnt", drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        apply(16'd9, 16'd9, 16'd2010, 1'b1, 1'b1);
        chk("post_rst_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
